divmod_arb: RTL and testbench

DIVMOD_ARB -- requirements
Module: divmod_arb

---
 rtl/divmod_arb_pkg.sv | 18 +
 rtl/divmod_arb_rr_pick.sv | 48 ++++
 rtl/divmod_arb.sv | 157 +++++++++++++++
 tb/tb_divmod_arb.sv | 389 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/divmod_arb_pkg.sv
// -----------------------------------------------------------------------------
// divmod_arb_pkg
// Shared definitions for the divmod_arb block:
//   - DEFAULT_WIDTH / DEFAULT_NREQ : default operand width and requester count
//   - ST_* : 3-bit FSM state encodings, also visible on the debug state port
// -----------------------------------------------------------------------------
package divmod_arb_pkg;

    localparam int DEFAULT_WIDTH = 16;
    localparam int DEFAULT_NREQ  = 4;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_ISSUE    = 3'd1;
    localparam logic [2:0] ST_WAIT_DLY = 3'd2;
    localparam logic [2:0] ST_WAIT     = 3'd3;
    localparam logic [2:0] ST_DONE     = 3'd4;

endpackage

// File: rtl/divmod_arb_rr_pick.sv
// -----------------------------------------------------------------------------
// divmod_arb_rr_pick
// Grant selection for divmod_arb. Purely combinational.
//   pending_i    : one bit per requester with a queued operation
//   last_grant_i : index of the most recently served requester
//   grant_o      : selected requester index (valid only when valid_o is high)
//   valid_o      : at least one pending bit is set
// Default: round-robin, search starts at (last_grant_i + 1) mod NREQ.
// With DIVMOD_ARB_FIXED_PRIO_EN defined: lowest pending index wins and
// last_grant_i is ignored.
// -----------------------------------------------------------------------------
module divmod_arb_rr_pick
    import divmod_arb_pkg::*;
#(
    parameter  int NREQ = DEFAULT_NREQ,
    localparam int GW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] pending_i,
    input  logic [GW-1:0]   last_grant_i,
    output logic [GW-1:0]   grant_o,
    output logic            valid_o
);

    always_comb begin
        grant_o = '0;
        valid_o = 1'b0;
`ifdef DIVMOD_ARB_FIXED_PRIO_EN
        // Walk from the highest index down so the lowest pending index is
        // the last (and therefore winning) assignment.
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (pending_i[GW'(k)]) begin
                grant_o = GW'(k);
                valid_o = 1'b1;
            end
        end
`else
        // Walk offsets from farthest to nearest so the nearest pending
        // requester after last_grant_i is the winning assignment.
        for (int k = NREQ; k >= 1; k--) begin
            if (pending_i[GW'((int'(last_grant_i) + k) % NREQ)]) begin
                grant_o = GW'((int'(last_grant_i) + k) % NREQ);
                valid_o = 1'b1;
            end
        end
`endif
    end

endmodule

// File: rtl/divmod_arb.sv
// -----------------------------------------------------------------------------
// divmod_arb
// Shares one external divmod unit between NREQ requesters.
// Ports:
//   clk, rst              : clock, synchronous active-low reset
//   req_go[i]             : rising edge requests an operation for requester i
//   req_a/req_b slice i   : dividend / divisor of requester i
//   req_ready[i]          : requester i has nothing pending or in flight
//   req_error[i]          : requester i's last operation ended in error
//   req_mod slice i       : requester i's last remainder (held)
//   dm_go, dm_a, dm_b     : command to the shared divmod unit
//   dm_ready, dm_error,
//   dm_mod                : status/result from the shared divmod unit
//   dbg_state_o           : current FSM state (ST_* encodings)
// Build option: DIVMOD_ARB_FIXED_PRIO_EN selects fixed-priority granting
// (lowest index first) instead of round-robin.
//
// Handshakes: a requester is accepted only on a req_go rising edge while its
// req_ready is high; req_ready stays low until the cycle after its operation
// completes. Towards the unit, dm_go is a one-cycle pulse with dm_a/dm_b held
// until completion; the unit is given one cycle (WAIT_DLY) to drop dm_ready,
// after which dm_error or dm_ready high ends the operation (error wins).
// -----------------------------------------------------------------------------
module divmod_arb
    import divmod_arb_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int NREQ  = DEFAULT_NREQ
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_go,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic [NREQ-1:0]       req_ready,
    output logic [NREQ-1:0]       req_error,
    output logic [NREQ*WIDTH-1:0] req_mod,
    output logic                  dm_go,
    output logic [WIDTH-1:0]      dm_a,
    output logic [WIDTH-1:0]      dm_b,
    input  logic                  dm_ready,
    input  logic                  dm_error,
    input  logic [WIDTH-1:0]      dm_mod,
    output logic [2:0]            dbg_state_o
);

    localparam int GW = $clog2(NREQ);

    logic [2:0]       state_q, state_d;
    logic [NREQ-1:0]  go_q;
    logic [NREQ-1:0]  pending_q, pending_d;
    logic [GW-1:0]    grant_q, grant_d;
    logic [GW-1:0]    last_q, last_d;
    logic [NREQ-1:0]  err_q, err_d;
    logic [WIDTH-1:0] mod_q [NREQ];
    logic [WIDTH-1:0] mod_d [NREQ];
    logic [WIDTH-1:0] op_a_q [NREQ];
    logic [WIDTH-1:0] op_b_q [NREQ];

    logic [NREQ-1:0]  accept;
    logic [GW-1:0]    pick_grant;
    logic             pick_valid;

    // pending covers both queued and in-flight operations, so ~pending is
    // exactly the ready condition.
    assign accept = req_go & ~go_q & ~pending_q;

    divmod_arb_rr_pick #(.NREQ(NREQ)) u_rr_pick (
        .pending_i    (pending_q),
        .last_grant_i (last_q),
        .grant_o      (pick_grant),
        .valid_o      (pick_valid)
    );

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q | accept;
        grant_d   = grant_q;
        last_d    = last_q;
        err_d     = err_q;
        mod_d     = mod_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    grant_d = pick_grant;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE:    state_d = ST_WAIT_DLY;
            ST_WAIT_DLY: state_d = ST_WAIT;
            ST_WAIT: begin
                if (dm_error) begin
                    err_d[grant_q] = 1'b1;
                    state_d        = ST_DONE;
                end else if (dm_ready) begin
                    mod_d[grant_q] = dm_mod;
                    err_d[grant_q] = 1'b0;
                    state_d        = ST_DONE;
                end
            end
            ST_DONE: begin
                pending_d[grant_q] = 1'b0;
                last_d             = grant_q;
                state_d            = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            pending_q <= '0;
            grant_q   <= '0;
            last_q    <= GW'(NREQ - 1);
            err_q     <= '0;
            for (int i = 0; i < NREQ; i++) begin
                mod_q[i] <= '0;
            end
            // Tracking the live level during reset means a go held high
            // across reset release is not seen as a rising edge.
            go_q      <= req_go;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
            err_q     <= err_d;
            mod_q     <= mod_d;
            go_q      <= req_go;
        end
    end

    // Operand registers need no reset: they are only read after a capture.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NREQ; i++) begin
            if (accept[i]) begin
                op_a_q[i] <= req_a[i*WIDTH +: WIDTH];
                op_b_q[i] <= req_b[i*WIDTH +: WIDTH];
            end
        end
    end

    assign req_ready   = ~pending_q;
    assign req_error   = err_q;
    assign dm_go       = (state_q == ST_ISSUE);
    // grant_q is frozen from ISSUE through DONE, and requester g cannot
    // recapture while pending, so these stay stable for the whole operation.
    assign dm_a        = op_a_q[grant_q];
    assign dm_b        = op_b_q[grant_q];
    assign dbg_state_o = state_q;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_mod_out
        assign req_mod[gi*WIDTH +: WIDTH] = mod_q[gi];
    end

endmodule

// File: tb/tb_divmod_arb.sv
module tb_divmod_arb;
  import divmod_arb_pkg::*;

  localparam int WIDTH = 16;
  localparam int NREQ  = 4;

  logic                  clk;
  logic                  rst;
  logic [NREQ-1:0]       req_go;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ-1:0]       req_error;
  logic [NREQ*WIDTH-1:0] req_mod;
  logic                  dm_go;
  logic [WIDTH-1:0]      dm_a;
  logic [WIDTH-1:0]      dm_b;
  logic                  dm_ready;
  logic                  dm_error;
  logic [WIDTH-1:0]      dm_mod;
  logic [2:0]            dbg_state;

  divmod_arb #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_go      (req_go),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_ready   (req_ready),
    .req_error   (req_error),
    .req_mod     (req_mod),
    .dm_go       (dm_go),
    .dm_a        (dm_a),
    .dm_b        (dm_b),
    .dm_ready    (dm_ready),
    .dm_error    (dm_error),
    .dm_mod      (dm_mod),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no end of test, expected end of test");
    $fatal(1, "watchdog expired");
  end

  // ---------------- bench state ----------------
  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int go_cnt = 0;
  int slow   = 0;

  logic [NREQ-1:0]  go_hold;
  logic [NREQ-1:0]  go_was;
  logic [NREQ-1:0]  outst;
  logic [NREQ-1:0]  inflight;
  int               issue_cyc [NREQ];
  int               served    [NREQ];
  int               issued    [NREQ];
  logic [WIDTH-1:0] cur_a     [NREQ];
  logic [WIDTH-1:0] cur_b     [NREQ];
  logic [WIDTH-1:0] exp_mod   [NREQ];
  logic             exp_err   [NREQ];
  logic [WIDTH-1:0] mdl_mod   [NREQ];
  logic             mdl_err   [NREQ];
  int               mdl_last;
  logic [WIDTH-1:0] exp_q [$];
  int               done_log [$];

  // ---------------- shared divmod unit model ----------------
  int               dm_lat;
  bit               dm_busy;
  logic [WIDTH-1:0] dm_a_l, dm_b_l;

  initial begin
    dm_ready = 1'b1;
    dm_error = 1'b0;
    dm_mod   = '0;
    dm_busy  = 1'b0;
    dm_lat   = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        dm_ready = 1'b1;
        dm_error = 1'b0;
        dm_busy  = 1'b0;
      end else if (dm_go) begin
        dm_ready = 1'b0;
        dm_error = 1'b0;
        dm_busy  = 1'b1;
        dm_a_l   = dm_a;
        dm_b_l   = dm_b;
        dm_lat   = (slow != 0) ? 12 : int'($urandom_range(1, 4));
      end else if (dm_busy) begin
        dm_lat--;
        if (dm_lat == 0) begin
          dm_busy  = 1'b0;
          dm_ready = 1'b1;
          if (dm_b_l == 0) begin
            dm_error = 1'b1;
            dm_mod   = 16'hDEAD;
          end else begin
            dm_mod   = dm_a_l % dm_b_l;
          end
        end
      end
    end
  end

  // ---------------- check / model helpers ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Next grant according to the arbitration rule, over the set of requesters
  // the arbiter could have seen at its decision point.
  function automatic int pick_model(input logic [NREQ-1:0] pend, input int last);
`ifdef DIVMOD_ARB_FIXED_PRIO_EN
    for (int k = 0; k < NREQ; k++) if (pend[k]) return k;
`else
    for (int k = 1; k <= NREQ; k++) if (pend[(last + k) % NREQ]) return (last + k) % NREQ;
`endif
    return -1;
  endfunction

  task automatic model_clear();
    outst    = '0;
    inflight = '0;
    exp_q.delete();
    mdl_last = NREQ - 1;
    for (int i = 0; i < NREQ; i++) begin
      mdl_mod[i] = '0;
      mdl_err[i] = 1'b0;
    end
  endtask

  task automatic complete(input int i);
    int e;
    if (exp_q.size() == 0) begin
      chk($sformatf("completion_without_grant%0d", i), 32'(i), 32'hFF);
    end else begin
      e = int'(exp_q.pop_front());
      chk("grant_order", 32'(i), 32'(e));
    end
    if (exp_err[i]) begin
      mdl_err[i] = 1'b1;
    end else begin
      mdl_mod[i] = exp_mod[i];
      mdl_err[i] = 1'b0;
    end
    // All requesters are compared: only requester i may have changed.
    for (int j = 0; j < NREQ; j++) begin
      chk($sformatf("req_mod%0d", j), 32'(req_mod[j*WIDTH +: WIDTH]), 32'(mdl_mod[j]));
      chk($sformatf("req_error%0d", j), 32'(req_error[j]), 32'(mdl_err[j]));
    end
    outst[i]    = 1'b0;
    inflight[i] = 1'b0;
    served[i]++;
    done_log.push_back(i);
  endtask

  // One cycle: advance to the falling edge, drop pulsed go bits, then
  // score any dm_go issue and any completion seen this cycle.
  task automatic tick();
    logic [NREQ-1:0] pend;
    int e;
    @(negedge clk);
    cyc++;
    go_was = req_go;
    req_go = req_go & go_hold;
    if (rst && dm_go) begin
      go_cnt++;
      pend = '0;
      for (int i = 0; i < NREQ; i++)
        pend[i] = outst[i] && !inflight[i] && (issue_cyc[i] <= cyc - 2);
      e = pick_model(pend, mdl_last);
      if (e < 0) begin
        chk("dm_go_unexpected", 32'd1, 32'd0);
      end else begin
        chk("dm_a", 32'(dm_a), 32'(cur_a[e]));
        chk("dm_b", 32'(dm_b), 32'(cur_b[e]));
        exp_q.push_back(WIDTH'(e));
        inflight[e] = 1'b1;
        mdl_last    = e;
      end
    end
    if (rst) begin
      for (int i = 0; i < NREQ; i++)
        if (outst[i] && req_ready[i]) complete(i);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_go(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    if (go_was[i]) return;
    req_a[i*WIDTH +: WIDTH] = a;
    req_b[i*WIDTH +: WIDTH] = b;
    req_go[i] = 1'b1;
    if (!outst[i]) begin
      outst[i]     = 1'b1;
      issue_cyc[i] = cyc;
      cur_a[i]     = a;
      cur_b[i]     = b;
      exp_err[i]   = (b == 0);
      exp_mod[i]   = (b == 0) ? '0 : a % b;
    end
  endtask

  task automatic wait_idle(input string tag);
    int budget;
    budget = 0;
    while (outst != '0 && budget < 400) begin
      tick();
      budget++;
    end
    if (outst != '0) chk({tag, "_timeout"}, 32'(outst), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    model_clear();
    repeat (2) tick();
    rst = 1'b1;
    tick();
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int c0, g0, k;
    rst     = 1'b0;
    req_go  = '0;
    req_a   = '0;
    req_b   = '0;
    go_hold = '0;
    go_was  = '0;
    for (int i = 0; i < NREQ; i++) begin
      issue_cyc[i] = 0;
      served[i]    = 0;
      issued[i]    = 0;
    end
    model_clear();

    // Reset state
    repeat (3) tick();
    chk("rst_ready", 32'(req_ready), 32'hF);
    chk("rst_error", 32'(req_error), 32'h0);
    chk("rst_mod", req_mod[31:0], 32'h0);
    chk("rst_mod_hi", req_mod[63:32], 32'h0);
    chk("rst_dm_go", 32'(dm_go), 32'h0);
    chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    rst = 1'b1;
    tick();

    // Single request: 100 mod 7
    c0 = cyc;
    g0 = go_cnt;
    drive_go(0, 16'd100, 16'd7);
    tick();
    chk("ready_drop", 32'(req_ready[0]), 32'd0);
    while (go_cnt == g0 && cyc - c0 < 10) tick();
    chk("go_latency", 32'((go_cnt > g0) && (cyc - c0 <= 4)), 32'd1);
    wait_idle("single");
    repeat (4) tick();
    chk("single_pulse", 32'(go_cnt - g0), 32'd1);
    chk("single_mod", 32'(req_mod[15:0]), 32'd2);
    chk("single_err", 32'(req_error[0]), 32'd0);
    chk("single_ready", 32'(req_ready[0]), 32'd1);

    // Simultaneous requests from 0 and 1
    do_reset();
    done_log.delete();
    drive_go(0, 16'd17, 16'd5);
    drive_go(1, 16'd20, 16'd6);
    wait_idle("simul");
    chk("simul_count", 32'(done_log.size()), 32'd2);
    if (done_log.size() == 2) begin
      chk("simul_first", 32'(done_log[0]), 32'd0);
      chk("simul_second", 32'(done_log[1]), 32'd1);
    end
    chk("simul_mod0", 32'(req_mod[15:0]), 32'd2);
    chk("simul_mod1", 32'(req_mod[31:16]), 32'd2);

    // Divisor zero on requester 2, then a normal request
    drive_go(2, 16'd50, 16'd0);
    wait_idle("err");
    chk("err_set", 32'(req_error[2]), 32'd1);
    chk("err_mod_kept", 32'(req_mod[47:32]), 32'd0);
    tick();
    drive_go(2, 16'd9, 16'd4);
    wait_idle("err_clr");
    chk("err_clear", 32'(req_error[2]), 32'd0);
    chk("err_mod", 32'(req_mod[47:32]), 32'd1);

    // Fairness: everyone re-requests as soon as it is ready
    do_reset();
    done_log.delete();
    for (int i = 0; i < NREQ; i++) begin
      served[i] = 0;
      issued[i] = 0;
    end
    k = 0;
    while (done_log.size() < 20 && k < 3000) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!outst[i] && !go_was[i] && issued[i] < 5) begin
          drive_go(i, WIDTH'($urandom_range(0, 65535)), WIDTH'($urandom_range(1, 1000)));
          issued[i]++;
        end
      end
      tick();
      k++;
    end
    chk("fair_total", 32'(done_log.size()), 32'd20);
    for (int i = 0; i < NREQ; i++) chk($sformatf("fair_served%0d", i), 32'(served[i]), 32'd5);
`ifndef DIVMOD_ARB_FIXED_PRIO_EN
    for (int n = 0; n < done_log.size(); n++)
      chk($sformatf("fair_seq%0d", n), 32'(done_log[n]), 32'(n % NREQ));
`endif

    // Requesters 3 and 1 together: 1 goes first under either policy
    do_reset();
    done_log.delete();
    drive_go(3, 16'd1000, 16'd7);
    drive_go(1, 16'd77, 16'd10);
    wait_idle("pair31");
    chk("pair31_count", 32'(done_log.size()), 32'd2);
    if (done_log.size() == 2) chk("pair31_first", 32'(done_log[0]), 32'd1);

    // Reset during WAIT, with requester 3 holding go across reset release
    slow = 1;
    tick();
    drive_go(1, 16'd500, 16'd33);
    k = 0;
    while (dbg_state !== ST_WAIT && k < 30) begin
      tick();
      k++;
    end
    chk("reach_wait", 32'(dbg_state), 32'(ST_WAIT));
    rst = 1'b0;
    model_clear();
    go_hold[3] = 1'b1;
    req_go[3]  = 1'b1;
    repeat (2) tick();
    chk("midrst_ready", 32'(req_ready), 32'hF);
    chk("midrst_dm_go", 32'(dm_go), 32'd0);
    chk("midrst_error", 32'(req_error), 32'd0);
    chk("midrst_mod1", 32'(req_mod[31:16]), 32'd0);
    rst = 1'b1;
    g0  = go_cnt;
    repeat (5) tick();
    chk("held_go_ignored", 32'(req_ready[3]), 32'd1);
    chk("held_go_no_issue", 32'(go_cnt - g0), 32'd0);
    go_hold = '0;
    slow    = 0;
    tick();
    drive_go(1, 16'd500, 16'd33);
    wait_idle("post_rst");
    chk("post_rst_mod", 32'(req_mod[31:16]), 32'd5);

    // Random traffic, including go pulses while busy (must be ignored)
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!outst[i] && $urandom_range(0, 3) == 0)
          drive_go(i, WIDTH'($urandom_range(0, 65535)),
                   ($urandom_range(0, 9) == 0) ? '0 : WIDTH'($urandom_range(1, 2000)));
        else if (outst[i] && $urandom_range(0, 7) == 0)
          drive_go(i, WIDTH'($urandom_range(0, 65535)), WIDTH'($urandom_range(0, 65535)));
      end
      tick();
    end
    wait_idle("random");
    repeat (6) tick();
    chk("random_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
